// File: rtl/mul_wb_pkg.sv
// Shared types and constants for the multiplier/ALU writeback arbiter.
//   REG_SIZE       : datapath width
//   REG_ADDR_W     : register-file address width
//   mul_wb_entry_t : one buffered multiplier result {result, zero, overflow, dst}
package mul_wb_pkg;

  localparam int unsigned REG_SIZE   = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_SIZE-1:0]   result;
    logic                  zero;
    logic                  overflow;
    logic [REG_ADDR_W-1:0] dst;
  } mul_wb_entry_t;

  // A multiplier result writes only when it did not overflow and targets a real register.
  function automatic logic entry_we(input mul_wb_entry_t e);
    return !e.overflow && (e.dst != '0);
  endfunction

endpackage

// File: rtl/mul_wb_fifo.sv
// Synchronous DEPTH-entry skid FIFO for multiplier results that lose arbitration.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   push, din      : write one entry (caller guarantees !full)
//   pop            : drop the head entry (caller guarantees !empty)
//   head           : current head entry (valid when !empty)
//   full, empty    : occupancy flags
//   count          : number of stored entries, 0..DEPTH
module mul_wb_fifo
  import mul_wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  mul_wb_entry_t    din,
  output mul_wb_entry_t    head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mul_wb_entry_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mul_wb_arbiter.sv
// Writeback arbiter after multiplier stage M3: merges the multiplier and ALU result
// streams onto the single register-file write port. ALU wins every conflict; losing
// multiplier results wait in a skid FIFO and back-pressure M3 when it is full.
// Multiplier overflow becomes a no-write plus a one-cycle exception pulse.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   mul_valid/result/zero/overflow/dst : M3 result (ignored while mul_stall)
//   mul_stall                          : combinational hold request to M3 (FIFO full)
//   alu_valid/result/dst               : single-cycle ALU result
//   wb_valid/we/result/dst/zero        : registered writeback slot
//   wb_from_mul                        : slot carries a multiplier result
//   mul_ovf_exc                        : overflow exception, aligned with its wb_valid
// DEPTH legal range is 2..4.
module mul_wb_arbiter
  import mul_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mul_valid,
  input  logic [REG_SIZE-1:0]   mul_result,
  input  logic                  mul_zero,
  input  logic                  mul_overflow,
  input  logic [REG_ADDR_W-1:0] mul_dst,
  output logic                  mul_stall,
  input  logic                  alu_valid,
  input  logic [REG_SIZE-1:0]   alu_result,
  input  logic [REG_ADDR_W-1:0] alu_dst,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_SIZE-1:0]   wb_result,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic                  wb_zero,
  output logic                  wb_from_mul,
  output logic                  mul_ovf_exc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             w_mul_acc;
  logic             w_push;
  logic             w_pop;
  logic             w_sel_mul;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_count;
  mul_wb_entry_t    w_mul_in;
  mul_wb_entry_t    w_head;
  mul_wb_entry_t    w_sel;

  assign w_mul_in = '{result: mul_result, zero: mul_zero, overflow: mul_overflow, dst: mul_dst};

  assign mul_stall = (w_count == CNT_W'(DEPTH));
  assign w_mul_acc = mul_valid && !w_fifo_full;

  // Buffered results drain before any new one; bypass only with an empty FIFO.
  assign w_pop     = !alu_valid && !w_fifo_empty;
  assign w_push    = w_mul_acc && (alu_valid || !w_fifo_empty);
  assign w_sel_mul = !alu_valid && (!w_fifo_empty || w_mul_acc);
  assign w_sel     = w_fifo_empty ? w_mul_in : w_head;

  mul_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_mul_in),
    .head  (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_count)
  );

  // Registered writeback slot; result, dst and zero hold when the slot is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_result   <= '0;
      wb_dst      <= '0;
      wb_zero     <= 1'b0;
      wb_from_mul <= 1'b0;
      mul_ovf_exc <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_from_mul <= 1'b0;
      mul_ovf_exc <= 1'b0;
      if (alu_valid) begin
        wb_valid  <= 1'b1;
        wb_we     <= (alu_dst != '0);
        wb_result <= alu_result;
        wb_dst    <= alu_dst;
        wb_zero   <= (alu_result == '0);
      end else if (w_sel_mul) begin
        wb_valid    <= 1'b1;
        wb_we       <= entry_we(w_sel);
        wb_result   <= w_sel.result;
        wb_dst      <= w_sel.dst;
        wb_zero     <= w_sel.zero;
        wb_from_mul <= 1'b1;
        mul_ovf_exc <= w_sel.overflow;
      end
    end
  end

endmodule

// File: tb/tb_mul_wb_arbiter.sv
// Scoreboard bench for mul_wb_arbiter: the driver queues expected slots per source,
// the negedge monitor pops and compares whenever wb_valid is presented.
module tb_mul_wb_arbiter;
  import mul_wb_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic                  clk;
  logic                  reset;
  logic                  mul_valid;
  logic [REG_SIZE-1:0]   mul_result;
  logic                  mul_zero;
  logic                  mul_overflow;
  logic [REG_ADDR_W-1:0] mul_dst;
  logic                  mul_stall;
  logic                  alu_valid;
  logic [REG_SIZE-1:0]   alu_result;
  logic [REG_ADDR_W-1:0] alu_dst;
  logic                  wb_valid;
  logic                  wb_we;
  logic [REG_SIZE-1:0]   wb_result;
  logic [REG_ADDR_W-1:0] wb_dst;
  logic                  wb_zero;
  logic                  wb_from_mul;
  logic                  mul_ovf_exc;

  mul_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .mul_valid    (mul_valid),
    .mul_result   (mul_result),
    .mul_zero     (mul_zero),
    .mul_overflow (mul_overflow),
    .mul_dst      (mul_dst),
    .mul_stall    (mul_stall),
    .alu_valid    (alu_valid),
    .alu_result   (alu_result),
    .alu_dst      (alu_dst),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_result    (wb_result),
    .wb_dst       (wb_dst),
    .wb_zero      (wb_zero),
    .wb_from_mul  (wb_from_mul),
    .mul_ovf_exc  (mul_ovf_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic                  we;
    logic [REG_SIZE-1:0]   result;
    logic [REG_ADDR_W-1:0] dst;
    logic                  zero;
    logic                  exc;
  } exp_t;

  exp_t q_alu[$];
  exp_t q_mul[$];
  exp_t m_exp;
  exp_t m_act;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every presented slot must match the oldest expected slot of its source.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_valid) begin
        m_act = '{we: wb_we, result: wb_result, dst: wb_dst, zero: wb_zero, exc: mul_ovf_exc};
        if (wb_from_mul && q_mul.size() > 0) begin
          m_exp = q_mul.pop_front();
          chk("mul_slot", 64'(m_act), 64'(m_exp));
        end else if (!wb_from_mul && q_alu.size() > 0) begin
          m_exp = q_alu.pop_front();
          chk("alu_slot", 64'(m_act), 64'(m_exp));
        end else begin
          chk("unexpected_slot", 64'({wb_from_mul, wb_dst, wb_result}), 64'(0));
        end
      end else begin
        chk("idle_we_exc", 64'({wb_we, mul_ovf_exc}), 64'(0));
      end
    end
  end

  // One cycle of stimulus; expected slots are queued for whatever the DUT accepts.
  task automatic drive(input logic av, input logic [31:0] ar, input logic [4:0] ad,
                       input logic mv, input logic [31:0] mr, input logic mo,
                       input logic [4:0] md, output logic acc);
    alu_valid    = av;
    alu_result   = ar;
    alu_dst      = ad;
    mul_valid    = mv;
    mul_result   = mr;
    mul_zero     = (mr == 32'd0);
    mul_overflow = mo;
    mul_dst      = md;
    acc = mv && !mul_stall;
    if (av) q_alu.push_back('{we: (ad != 5'd0), result: ar, dst: ad, zero: (ar == 32'd0), exc: 1'b0});
    if (acc) q_mul.push_back('{we: (!mo && md != 5'd0), result: mr, dst: md, zero: (mr == 32'd0), exc: mo});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, a);
  endtask

  initial begin
    logic acc;
    int   idx;
    reset = 1'b1;
    alu_valid = 1'b0; alu_result = '0; alu_dst = '0;
    mul_valid = 1'b0; mul_result = '0; mul_zero = 1'b0; mul_overflow = 1'b0; mul_dst = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_wb_valid", 64'(wb_valid), 64'(0));
    chk("rst_wb_we", 64'(wb_we), 64'(0));
    chk("rst_exc", 64'(mul_ovf_exc), 64'(0));
    chk("rst_stall", 64'(mul_stall), 64'(0));
    chk("rst_count", 64'(dut.w_count), 64'(0));

    // Multiplier alone: bypass with 1-cycle latency
    drive(1'b0, 32'd0, 5'd0, 1'b1, 32'h0000_0007, 1'b0, 5'd3, acc);
    chk("t1_latency", 64'({wb_valid, wb_from_mul, wb_dst}), 64'({1'b1, 1'b1, 5'd3}));
    idle(1);

    // Conflict: ALU first, buffered multiplier result next cycle
    drive(1'b1, 32'h10, 5'd4, 1'b1, 32'h20, 1'b0, 5'd5, acc);
    chk("t2_alu_first", 64'({wb_from_mul, wb_dst}), 64'({1'b0, 5'd4}));
    chk("t2_count_peak", 64'(dut.w_count), 64'(1));
    idle(1);
    chk("t2_mul_second", 64'({wb_from_mul, wb_dst}), 64'({1'b1, 5'd5}));
    chk("t2_count_empty", 64'(dut.w_count), 64'(0));
    idle(1);

    // Back-pressure: 4 ALU cycles against 3 multiplier results held under stall
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      drive(c < 4, 32'h100 + 32'(c), 5'(8 + c), idx < 3, 32'hA0 + 32'(idx), 1'b0, 5'(20 + idx), acc);
      if (acc) idx++;
      if (c == 1) chk("t3_stall_after_2", 64'(mul_stall), 64'(1));
    end
    chk("t3_all_accepted", 64'(idx), 64'(3));
    idle(2);
    chk("t3_drained", 64'(q_mul.size() + q_alu.size()), 64'(0));

    // Overflow: no write, one-cycle exception
    drive(1'b0, 32'd0, 5'd0, 1'b1, 32'h1234, 1'b1, 5'd7, acc);
    chk("t4_ovf", 64'({wb_valid, wb_we, mul_ovf_exc}), 64'({1'b1, 1'b0, 1'b1}));
    idle(1);
    chk("t4_exc_pulse", 64'(mul_ovf_exc), 64'(0));

    // $zero destination from both sources
    drive(1'b0, 32'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0, acc);
    chk("t5_mul_r0", 64'({wb_valid, wb_we, mul_ovf_exc}), 64'({1'b1, 1'b0, 1'b0}));
    drive(1'b1, 32'd5, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, acc);
    chk("t5_alu_r0", 64'({wb_valid, wb_we}), 64'({1'b1, 1'b0}));
    idle(1);

    // Reset with two buffered entries: nothing stale may appear afterwards
    drive(1'b1, 32'h31, 5'd1, 1'b1, 32'h41, 1'b0, 5'd9, acc);
    drive(1'b1, 32'h32, 5'd2, 1'b1, 32'h42, 1'b0, 5'd10, acc);
    chk("t6_count_full", 64'(dut.w_count), 64'(2));
    chk("t6_stall_full", 64'(mul_stall), 64'(1));
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    q_alu.delete();
    q_mul.delete();
    chk("t6_count_rst", 64'(dut.w_count), 64'(0));
    chk("t6_valid_rst", 64'(wb_valid), 64'(0));
    chk("t6_stall_rst", 64'(mul_stall), 64'(0));
    idle(4);
    chk("t6_no_stale", 64'(q_mul.size() + q_alu.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
